// File: rtl/axi4_wr_arbiter_pkg.sv
// Shared types and AXI4 constants for the DDR write-port arbiter.
// Also holds the one-hot to index helper used when muxing master slices.
package axi4_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_32B    = 3'b101;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [1:0] oh2idx(input logic [3:0] i_oh);
    logic [1:0] w_idx;
    w_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (i_oh[i]) begin
        w_idx = 2'(i);
      end else begin
        w_idx = w_idx;
      end
    end
    return w_idx;
  endfunction

endpackage

// File: rtl/axi4_wr_arbiter_if.sv
// Bus bundle between the write engines (i_m_*/o_m_*) and the DDR AXI4 write port.
// master: the arbiter's view (it masters the DDR port); slave: the environment's view.
interface axi4_wr_arbiter_if #(
  parameter int pMasterNum    = 2,
  parameter int pAxi4BusWidth = 512,
  parameter int pAdrsWidth    = 33
);
  logic [pMasterNum*pAdrsWidth-1:0]    i_m_awaddr;
  logic [pMasterNum*8-1:0]             i_m_awlen;
  logic [pMasterNum-1:0]               i_m_awvalid;
  logic [pMasterNum-1:0]               o_m_awready;
  logic [pMasterNum*pAxi4BusWidth-1:0] i_m_wdata;
  logic [pMasterNum-1:0]               i_m_wlast;
  logic [pMasterNum-1:0]               i_m_wvalid;
  logic [pMasterNum-1:0]               o_m_wready;
  logic [1:0]                          o_m_bresp;
  logic [pMasterNum-1:0]               o_m_bvalid;
  logic [pMasterNum-1:0]               i_m_bready;
  logic [pAdrsWidth-1:0]               o_awaddr;
  logic [7:0]                          o_awlen;
  logic [2:0]                          o_awsize;
  logic [1:0]                          o_awburst;
  logic                                o_awvalid;
  logic                                i_awready;
  logic [pAxi4BusWidth-1:0]            o_wdata;
  logic                                o_wlast;
  logic                                o_wvalid;
  logic                                i_wready;
  logic [1:0]                          i_bresp;
  logic                                i_bvalid;
  logic                                o_bready;

  modport master (
    input  i_m_awaddr, i_m_awlen, i_m_awvalid, i_m_wdata, i_m_wlast, i_m_wvalid, i_m_bready,
    input  i_awready, i_wready, i_bresp, i_bvalid,
    output o_m_awready, o_m_wready, o_m_bresp, o_m_bvalid,
    output o_awaddr, o_awlen, o_awsize, o_awburst, o_awvalid, o_wdata, o_wlast, o_wvalid, o_bready
  );

  modport slave (
    output i_m_awaddr, i_m_awlen, i_m_awvalid, i_m_wdata, i_m_wlast, i_m_wvalid, i_m_bready,
    output i_awready, i_wready, i_bresp, i_bvalid,
    input  o_m_awready, o_m_wready, o_m_bresp, o_m_bvalid,
    input  o_awaddr, o_awlen, o_awsize, o_awburst, o_awvalid, o_wdata, o_wlast, o_wvalid, o_bready
  );
endinterface

// File: rtl/axi4_wr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
// Shared with the read-side arbiter, so it knows nothing about AXI.
module rr_arbiter #(
  parameter int pN  = 2,
  parameter int pPW = 1
) (
  input  logic [pN-1:0]  i_req,
  input  logic [pPW-1:0] i_ptr,
  output logic [pN-1:0]  o_gnt
);
  logic           w_found;
  logic [pPW-1:0] w_idx;

  // Scan requesters starting at the pointer, wrapping modulo pN
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int off = 0; off < pN; off++) begin
      w_idx = pPW'((int'(i_ptr) + off) % pN);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end
endmodule

// File: rtl/axi4_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4 write port (AW/W/B) among pMasterNum engines.
// A single master owns a complete AW -> W burst -> B transaction at a time.
module axi4_wr_arbiter
  import axi4_arb_pkg::*;
#(
  parameter int pMasterNum    = 2,
  parameter int pAxi4BusWidth = 512,
  parameter int pAdrsWidth    = 33
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  axi4_wr_arbiter_if.master     bus,
  output logic [pMasterNum-1:0] o_grant,
  output logic                  o_busy,
  output logic                  o_err
);
  localparam int PW = $clog2(pMasterNum);

  arb_state_e            r_state;
  arb_state_e            w_next;
  logic [pMasterNum-1:0] r_grant;
  logic [pMasterNum-1:0] w_rr_gnt;
  logic [PW-1:0]         r_ptr;
  logic [PW-1:0]         w_g;
  logic [7:0]            r_cnt;
  logic [7:0]            r_awlen;
  logic                  r_err;
  logic                  w_any_req;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;

  rr_arbiter #(.pN(pMasterNum), .pPW(PW)) u_rr (
    .i_req (bus.i_m_awvalid),
    .i_ptr (r_ptr),
    .o_gnt (w_rr_gnt)
  );

  assign w_g       = PW'(oh2idx(4'(r_grant)));
  assign w_any_req = |bus.i_m_awvalid;
  assign w_aw_hs   = (r_state == ST_ADDR) && bus.i_m_awvalid[w_g] && bus.i_awready;
  assign w_w_hs    = (r_state == ST_DATA) && bus.i_m_wvalid[w_g] && bus.i_wready;
  assign w_b_hs    = (r_state == ST_RESP) && bus.i_bvalid && bus.i_m_bready[w_g];

  assign bus.o_awsize  = SIZE_32B;
  assign bus.o_awburst = BURST_INCR;
  assign o_grant       = r_grant;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_err         = r_err;

  // State register
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and channel routing; only the granted master's lanes are ever opened
  always_comb begin
    w_next          = r_state;
    bus.o_m_awready = '0;
    bus.o_m_wready  = '0;
    bus.o_m_bvalid  = '0;
    bus.o_m_bresp   = 2'b00;
    bus.o_awaddr    = '0;
    bus.o_awlen     = 8'd0;
    bus.o_awvalid   = 1'b0;
    bus.o_wdata     = '0;
    bus.o_wlast     = 1'b0;
    bus.o_wvalid    = 1'b0;
    bus.o_bready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_next = ST_ADDR;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_ADDR: begin
        bus.o_awaddr         = bus.i_m_awaddr[w_g*pAdrsWidth +: pAdrsWidth];
        bus.o_awlen          = bus.i_m_awlen[w_g*8 +: 8];
        bus.o_awvalid        = bus.i_m_awvalid[w_g];
        bus.o_m_awready[w_g] = bus.i_awready;
        if (w_aw_hs) begin
          w_next = ST_DATA;
        end else begin
          w_next = ST_ADDR;
        end
      end
      ST_DATA: begin
        bus.o_wdata         = bus.i_m_wdata[w_g*pAxi4BusWidth +: pAxi4BusWidth];
        bus.o_wlast         = bus.i_m_wlast[w_g];
        bus.o_wvalid        = bus.i_m_wvalid[w_g];
        bus.o_m_wready[w_g] = bus.i_wready;
        if (w_w_hs && bus.i_m_wlast[w_g]) begin
          w_next = ST_RESP;
        end else begin
          w_next = ST_DATA;
        end
      end
      ST_RESP: begin
        bus.o_m_bvalid[w_g] = bus.i_bvalid;
        bus.o_m_bresp       = bus.i_bresp;
        bus.o_bready        = bus.i_m_bready[w_g];
        if (w_b_hs) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_RESP;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Grant, rr pointer, latched burst length, beat counter and sticky length error
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_grant <= '0;
      r_ptr   <= '0;
      r_awlen <= 8'd0;
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_any_req) r_grant <= w_rr_gnt;
        ST_ADDR: if (w_aw_hs) r_awlen <= bus.i_m_awlen[w_g*8 +: 8];
        ST_DATA: begin
          if (w_w_hs) begin
            if (bus.i_m_wlast[w_g]) begin
              r_cnt <= 8'd0;
              if (r_cnt != r_awlen) r_err <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 8'd1;
              if (r_cnt == r_awlen) r_err <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (w_b_hs) begin
            r_grant <= '0;
            if (int'(w_g) == pMasterNum - 1) r_ptr <= '0;
            else                             r_ptr <= w_g + 1'b1;
          end
        end
        default: r_grant <= '0;
      endcase
    end
  end
endmodule
